// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: request/response and word-memory bus of the load/store sequencer
interface lsu_ctrl_if #(
  parameter int ADDR_W = 17
);
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [1:0] req_size;
  logic req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0] req_wdata;
  logic rsp_valid;
  logic [31:0] rsp_rdata;
  logic rsp_err;
  logic mem_en;
  logic [3:0] mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport slave (
    input req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: byte/half/word load-store sequencer onto word memory; define LSU_MISALIGN_EN to split word-crossing accesses
module lsu_ctrl #(
  parameter int ADDR_W = 17
) (
  input logic clk,
  input logic rst,
  lsu_ctrl_if.slave bus
);
`ifdef LSU_MISALIGN_EN
  typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, ACC0, CAP, RESP} state_t;
`endif
  state_t state, nxt;
  logic we_r, uns_r, err_r, hs, err_in;
  logic [1:0] size_r, off;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-3:0] w0, w1;
  logic [31:0] wdata_r, rdata_r, lo, hi, r, ext;
  logic [7:0] be64;
  logic [63:0] wd64;
  function automatic logic crosses(input logic [1:0] size, input logic [1:0] o);
    return ({1'b0, o} + (size == 2'd0 ? 3'd1 : size == 2'd1 ? 3'd2 : 3'd4)) > 3'd4;
  endfunction
`ifdef LSU_MISALIGN_EN
  logic cross;
  logic [31:0] lo_buf, hi_buf;
  assign cross = crosses(size_r, off);
  assign err_in = bus.req_size == 2'b11;
  assign lo = cross ? lo_buf : bus.mem_rdata;
  assign hi = cross ? bus.mem_rdata : 32'd0;
  assign bus.mem_en = !rst && (state == ACC0 || state == ACC1);
  always_ff @(posedge clk)
    if (rst) begin
      lo_buf <= '0;
      hi_buf <= '0;
    end else if (state == ACC1 && !we_r) lo_buf <= bus.mem_rdata;
    else if (state == CAP && cross) hi_buf <= bus.mem_rdata;
    else if (state == CAP) lo_buf <= bus.mem_rdata;
`else
  assign err_in = bus.req_size == 2'b11 || crosses(bus.req_size, bus.req_addr[1:0]);
  assign lo = bus.mem_rdata;
  assign hi = 32'd0;
  assign bus.mem_en = !rst && state == ACC0;
`endif
  assign hs = bus.req_valid && bus.req_ready;
  assign bus.req_ready = !rst && state == IDLE;
  assign off = addr_r[1:0];
  assign w0 = addr_r[ADDR_W-1:2];
  assign w1 = w0 + (ADDR_W-2)'(1);
  assign be64 = (size_r == 2'd0 ? 8'h01 : size_r == 2'd1 ? 8'h03 : 8'h0f) << off;
  assign wd64 = {32'd0, wdata_r} << {off, 3'b000};
  assign r = 32'({hi, lo} >> {off, 3'b000});
  assign ext = size_r == 2'd0 ? {{24{!uns_r && r[7]}}, r[7:0]} :
               size_r == 2'd1 ? {{16{!uns_r && r[15]}}, r[15:0]} : r;
  assign bus.mem_addr = state == ACC0 ? w0 : w1;
  assign bus.mem_we = bus.mem_en && we_r ? (state == ACC0 ? be64[3:0] : be64[7:4]) : 4'd0;
  assign bus.mem_wdata = state == ACC0 ? wd64[31:0] : wd64[63:32];
  assign bus.rsp_valid = !rst && state == RESP;
  assign bus.rsp_err = bus.rsp_valid && err_r;
  assign bus.rsp_rdata = rdata_r;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = hs ? (err_in ? RESP : ACC0) : IDLE;
`ifdef LSU_MISALIGN_EN
      ACC0: nxt = cross ? ACC1 : we_r ? RESP : CAP;
      ACC1: nxt = we_r ? RESP : CAP;
`else
      ACC0: nxt = we_r ? RESP : CAP;
`endif
      CAP: nxt = RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      we_r <= 1'b0;
      uns_r <= 1'b0;
      err_r <= 1'b0;
      size_r <= 2'd0;
      addr_r <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
    end else begin
      state <= nxt;
      if (hs) begin
        we_r <= bus.req_we;
        uns_r <= bus.req_unsigned;
        size_r <= bus.req_size;
        addr_r <= bus.req_addr;
        wdata_r <= bus.req_wdata;
        err_r <= err_in;
      end
      if (nxt == RESP) rdata_r <= state == CAP ? ext : 32'd0;
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: vector table, corner sequences and random traffic against a byte-level memory model
module tb_lsu_ctrl;
  localparam int ADDR_W = 17;
`ifdef LSU_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  typedef struct {
    string nm;
    logic we;
    logic [1:0] sz;
    logic u;
    logic [16:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic er;
    int lat;
    int nen;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  lsu_ctrl_if #(.ADDR_W(ADDR_W)) bus();
  lsu_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] mem [0:32767];
  logic [7:0] rb [0:131071];
  logic bd_en = 1'b0;
  logic [14:0] bd_a = '0;
  logic [31:0] bd_d = '0;
  int checks = 0;
  int errors = 0;
  int viol = 0;
  logic [14:0] acc_addr [4];
  logic [3:0] acc_we [4];
  logic [31:0] acc_wd [4];
  vec_t vq [$];
  always @(posedge clk) begin
    if (!bus.mem_en && bus.mem_we != 4'd0) viol <= viol + 1;
    if (bd_en) mem[bd_a] <= bd_d;
    else if (bus.mem_en) begin
      if (bus.mem_we == 4'd0) bus.mem_rdata <= mem[bus.mem_addr];
      else for (int k = 0; k < 4; k++) if (bus.mem_we[k]) mem[bus.mem_addr][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
    end
  end
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] rbw(input int w);
    return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
  endfunction
  function automatic vec_t mk(input string nm, input logic we, input logic [1:0] sz, input logic u,
                              input logic [16:0] a, input logic [31:0] wd, input logic [31:0] rd,
                              input logic er, input int lat, input int nen);
    vec_t v;
    v.nm = nm; v.we = we; v.sz = sz; v.u = u; v.a = a; v.wd = wd;
    v.rd = rd; v.er = er; v.lat = lat; v.nen = nen;
    return v;
  endfunction
  task automatic setw(input int w, input logic [31:0] d);
    bd_a = 15'(w);
    bd_d = d;
    bd_en = 1'b1;
    for (int i = 0; i < 4; i++) rb[4*w+i] = d[8*i +: 8];
    @(posedge clk);
    #1 bd_en = 1'b0;
  endtask
  task automatic model(input logic we, input logic [1:0] sz, input logic u, input logic [16:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output int nen);
    int nb;
    bit cr;
    nb = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    cr = (int'(a[1:0]) + nb) > 4;
    er = sz == 2'd3 || (cr && !MIS);
    rd = '0;
    lat = 1;
    nen = 0;
    if (!er) begin
      nen = cr ? 2 : 1;
      lat = (we ? 2 : 3) + (cr ? 1 : 0);
      for (int i = 0; i < nb; i++)
        if (we) rb[17'(a + 17'(i))] = wd[8*i +: 8];
        else rd[8*i +: 8] = rb[17'(a + 17'(i))];
      if (!we && !u && nb < 4 && rd[8*nb-1]) for (int i = nb; i < 4; i++) rd[8*i +: 8] = 8'hff;
    end
  endtask
  task automatic do_req(input logic we, input logic [1:0] sz, input logic u, input logic [16:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int nen);
    int w;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      acc_addr[i] = '0;
      acc_we[i] = '0;
      acc_wd[i] = '0;
    end
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_size = sz;
    bus.req_unsigned = u;
    bus.req_addr = a;
    bus.req_wdata = wd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rd = '0;
    er = 1'b0;
    nen = 0;
    lat = 11;
    for (int c = 1; c <= 10; c++) begin
      if (bus.mem_en && nen < 4) begin
        acc_addr[nen] = bus.mem_addr;
        acc_we[nen] = bus.mem_we;
        acc_wd[nen] = bus.mem_wdata;
      end
      if (bus.mem_en) nen++;
      if (bus.rsp_valid) begin
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        lat = c;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    chk("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
  endtask
  task automatic run_vec(input vec_t v);
    logic [31:0] rd, mrd;
    logic er, mer;
    int lat, nen, mlat, mnen;
    model(v.we, v.sz, v.u, v.a, v.wd, mrd, mer, mlat, mnen);
    do_req(v.we, v.sz, v.u, v.a, v.wd, rd, er, lat, nen);
    chk({v.nm, "_rdata"}, rd, v.rd);
    chk({v.nm, "_err"}, 32'(er), 32'(v.er));
    chk({v.nm, "_lat"}, lat, v.lat);
    chk({v.nm, "_nen"}, nen, v.nen);
  endtask
  initial begin
    logic [31:0] rd, mrd;
    logic er, mer;
    int lat, nen, mlat, mnen, bad;
    logic we, u;
    logic [1:0] sz;
    logic [16:0] a;
    logic [31:0] wd;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 131072; i++) rb[i] = 8'h00;
    for (int w = 0; w < 32; w++) setw(w, $urandom);
    for (int w = 32'h7ff0; w < 32'h8000; w++) setw(w, $urandom);
    setw(0, 32'h0000bbaa);
    setw(1, 32'h000000f1);
    setw(2, 32'ha5a5a5a5);
    setw(4, 32'h80aabbcc);
    setw(32'h40, 32'h12345678);
    setw(32'h41, 32'h0);
    setw(32'h42, 32'h0);
    setw(32'h7fff, 32'hddcc0000);
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_rst_mem_en", 32'(bus.mem_en), 32'd0);
    vq.push_back(mk("lb_13", 0, 2'd0, 0, 17'h00013, 0, 32'hffffff80, 0, 3, 1));
    vq.push_back(mk("lbu_13", 0, 2'd0, 1, 17'h00013, 0, 32'h00000080, 0, 3, 1));
    vq.push_back(mk("lb_10", 0, 2'd0, 0, 17'h00010, 0, 32'hffffffcc, 0, 3, 1));
    vq.push_back(mk("lhu_11", 0, 2'd1, 1, 17'h00011, 0, 32'h0000aabb, 0, 3, 1));
    vq.push_back(mk("lh_11", 0, 2'd1, 0, 17'h00011, 0, 32'hffffaabb, 0, 3, 1));
    vq.push_back(mk("lh_0a", 0, 2'd1, 0, 17'h0000a, 0, 32'hffffa5a5, 0, 3, 1));
    vq.push_back(mk("lw_10", 0, 2'd2, 0, 17'h00010, 0, 32'h80aabbcc, 0, 3, 1));
    vq.push_back(mk("lbu_07", 0, 2'd0, 1, 17'h00007, 0, 32'h00000000, 0, 3, 1));
    vq.push_back(mk("ld_ill", 0, 2'd3, 0, 17'h00020, 0, 32'h0, 1, 1, 0));
    vq.push_back(mk("st_ill", 1, 2'd3, 0, 17'h00022, 32'hffffffff, 32'h0, 1, 1, 0));
    vq.push_back(mk("lh_03", 0, 2'd1, 0, 17'h00003, 0, MIS ? 32'hfffff100 : 32'h0, !MIS, MIS ? 4 : 1, MIS ? 2 : 0));
    vq.push_back(mk("lw_wrap", 0, 2'd2, 0, 17'h1fffe, 0, MIS ? 32'hbbaaddcc : 32'h0, !MIS, MIS ? 4 : 1, MIS ? 2 : 0));
    foreach (vq[i]) run_vec(vq[i]);
    model(1, 2'd1, 0, 17'h00102, 32'h0000beef, mrd, mer, mlat, mnen);
    do_req(1, 2'd1, 0, 17'h00102, 32'h0000beef, rd, er, lat, nen);
    chk("sh_lat", lat, 32'd2);
    chk("sh_nen", nen, 32'd1);
    chk("sh_err", 32'(er), 32'd0);
    chk("sh_rdata", rd, 32'd0);
    chk("sh_addr", 32'(acc_addr[0]), 32'h40);
    chk("sh_we", 32'(acc_we[0]), 32'hc);
    chk("sh_wdata_hi", 32'(acc_wd[0][31:16]), 32'hbeef);
    run_vec(mk("lh_102", 0, 2'd1, 0, 17'h00102, 0, 32'hffffbeef, 0, 3, 1));
    run_vec(mk("lhu_100", 0, 2'd1, 1, 17'h00100, 0, 32'h00005678, 0, 3, 1));
    model(1, 2'd2, 0, 17'h00007, 32'h11223344, mrd, mer, mlat, mnen);
    do_req(1, 2'd2, 0, 17'h00007, 32'h11223344, rd, er, lat, nen);
    chk("sw7_lat", lat, MIS ? 32'd3 : 32'd1);
    chk("sw7_err", 32'(er), 32'(!MIS));
    chk("sw7_nen", nen, MIS ? 32'd2 : 32'd0);
    chk("sw7_addr0", 32'(acc_addr[0]), MIS ? 32'h1 : 32'h0);
    chk("sw7_we0", 32'(acc_we[0]), MIS ? 32'h8 : 32'h0);
    chk("sw7_wd0", 32'(acc_wd[0][31:24]), MIS ? 32'h44 : 32'h0);
    chk("sw7_addr1", 32'(acc_addr[1]), MIS ? 32'h2 : 32'h0);
    chk("sw7_we1", 32'(acc_we[1]), MIS ? 32'h7 : 32'h0);
    chk("sw7_wd1", 32'(acc_wd[1][23:0]), MIS ? 32'h112233 : 32'h0);
    run_vec(mk("lw_07", 0, 2'd2, 0, 17'h00007, 0, MIS ? 32'h11223344 : 32'h0, !MIS, MIS ? 4 : 1, MIS ? 2 : 0));
    chk("abort_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_size = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 17'h00105;
    bus.req_wdata = 32'hcafef00d;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_mem_en", 32'(bus.mem_en), 32'd0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_rst_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", 32'(bus.req_ready), 32'd1);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.mem_en || bus.rsp_valid) bad++;
      @(negedge clk);
    end
    chk("abort_quiet", bad, 32'd0);
    chk("abort_w41", mem[32'h41], rbw(32'h41));
    chk("abort_w42", mem[32'h42], rbw(32'h42));
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      bad = int'($urandom_range(0, 7));
      sz = bad == 7 ? 2'd3 : 2'(bad % 3);
      a = $urandom_range(0, 1) ? 17'($urandom_range(0, 127)) : 17'(32'h1ffc0 + $urandom_range(0, 63));
      wd = $urandom;
      model(we, sz, u, a, wd, mrd, mer, mlat, mnen);
      do_req(we, sz, u, a, wd, rd, er, lat, nen);
      chk("rnd_rdata", rd, mrd);
      chk("rnd_err", 32'(er), 32'(mer));
      chk("rnd_lat", lat, mlat);
      chk("rnd_nen", nen, mnen);
    end
    bad = 0;
    for (int w = 0; w < 32; w++) if (mem[w] !== rbw(w)) bad++;
    for (int w = 32'h40; w < 32'h43; w++) if (mem[w] !== rbw(w)) bad++;
    for (int w = 32'h7ff0; w < 32'h8000; w++) if (mem[w] !== rbw(w)) bad++;
    chk("mem_final", bad, 32'd0);
    chk("we_without_en", viol, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the core's memory stage and the word-organised data memory. Accepts one byte/half/word load or store at a time over a valid/ready request port. Converts it into word-addressed memory accesses with byte enables, and returns sign- or zero-extended load data as a one-cycle response pulse. Accesses that cross a word boundary are split into two consecutive word accesses; this split is compile-time optional.

## Interface
Parameters:
- ADDR_W, 17, byte address width; word address width is ADDR_W-2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE and not in reset; handshake when req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores and word loads.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid; access rejected, no memory side effect.
- mem_en  out  1  memory access this cycle.
- mem_we  out  4  byte write enables; nonzero only with mem_en.
- mem_addr  out  ADDR_W-2  word address.
- mem_wdata  out  32  lane-aligned write data.
- mem_rdata  in  32  read data, valid the cycle after a read (mem_en=1, mem_we=0).

## Operation
- States: IDLE, ACC0, ACC1, CAP, RESP.
- On handshake, latch we/size/unsigned/addr/wdata.
- Derived values from the latched request:
  - off = addr[1:0]; w0 = addr>>2; w1 = w0+1 modulo 2^(ADDR_W-2), so 0x7FFF wraps to 0x0000.
  - bytes = 1/2/4 for size 00/01/10.
  - cross = off+bytes > 4, i.e. half at off 3, or word at off 1–3.
  - be64 = ((1<<bytes)-1) << off; wd64 = wdata << 8*off.
  - Low halves drive the w0 access, high halves drive the w1 access.
- Error: size==11, or cross with the macro off. IDLE→RESP with rsp_err=1; mem_en never asserts.
- Transitions:
  - IDLE→ACC0 on a non-error handshake.
  - ACC0 issues the w0 access. Next state is ACC1 if cross; otherwise CAP for loads and RESP for stores.
  - ACC1 issues the w1 access. For loads it captures mem_rdata (w0) into lo_buf and goes to CAP; for stores it goes to RESP.
  - CAP captures mem_rdata into lo_buf (non-cross) or hi_buf (cross), then goes to RESP.
  - RESP drives rsp_valid=1, then returns to IDLE.
- Load data:
  - r64 = {hi_buf, lo_buf} >> 8*off; hi_buf is treated as 0 when not crossing.
  - rsp_rdata = r64[8*bytes-1:0], sign-extended from its top bit, or zero-extended when req_unsigned=1.
  - rsp_rdata is registered on entry to RESP.
- Stores never read memory; byte enables replace read-modify-write. Unselected memory bytes are untouched.
- No rsp_ready: the core must accept rsp_valid when it occurs. No request queueing; req_ready=0 outside IDLE.

## Timing
- Reset values (while rst=1 and the cycle after):
  - state IDLE; req_ready=0 during rst.
  - rsp_valid, rsp_err, mem_en = 0; mem_we = 0; rsp_rdata = 0; buffers = 0.
- Handshake at cycle T. Latency to rsp_valid:
  - aligned load T+3; crossing load T+4.
  - aligned store T+2; crossing store T+3.
  - error T+1.
- mem_en cycles:
  - aligned: T+1.
  - crossing: T+1 (w0) and T+2 (w1), back-to-back.
- Next handshake is possible at the cycle after RESP.
- rst asserted mid-operation aborts the operation:
  - no mem_en in any cycle with rst=1 or after;
  - no rsp_valid for the aborted request;
  - a completed ACC0 write of a crossing store is not undone.

## Configuration
- LSU_MISALIGN_EN defined: crossing accesses are split as above.
- LSU_MISALIGN_EN undefined:
  - any crossing access gives an error response at T+1 with no memory access;
  - the ACC1 state and hi_buf are not built.
- Non-crossing unaligned accesses (byte anywhere, half at off 0–2) work in both builds.

## Test plan
- LB at 0x00013, mem word 0x0004 = 0x80AABBCC → mem_addr 0x0004, mem_we 0; rsp_rdata 0xFFFFFF80 at T+3, rsp_err 0. Same access as LBU → 0x00000080.
- SH 0xBEEF at 0x00102 → single cycle at T+1, mem_addr 0x0040, mem_we 0b1100, mem_wdata[31:16]=0xBEEF; rsp_valid at T+2.
- SW 0x11223344 at 0x00007 (macro on) → T+1: addr 0x0001, we 0b1000, wdata[31:24]=0x44. T+2: addr 0x0002, we 0b0111, wdata[23:0]=0x112233. rsp_valid at T+3.
- LW at 0x1FFFE (macro on), word 0x7FFF = 0xDDCC0000, word 0x0000 = 0x0000BBAA → reads 0x7FFF then 0x0000; rsp_rdata 0xBBAADDCC at T+4.
- Macro off, LH at 0x00003 → rsp_valid and rsp_err 1 at T+1, rsp_rdata 0, mem_en never high. req_size=11 → same response in both builds.
- rst pulsed at T+1 of a crossing store → no mem_en from T+1 onward, no rsp_valid; req_ready=1 the first cycle after rst falls.
